// File: rtl/wb_interconnect_dec.sv
// wb_interconnect_dec: Wishbone 1-initiator-to-N-target address decoder/router with unmapped-access error.
// Define WB_DEC_TIMEOUT_EN to add a watchdog that ends stalled ACTIVE accesses with an error.
module wb_interconnect_dec #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int N_TGT = 2,
    parameter logic [N_TGT*ADR_WIDTH-1:0] TGT_ADDR_BASE = '0,
    parameter logic [N_TGT*ADR_WIDTH-1:0] TGT_ADDR_MASK = '0,
    parameter int TIMEOUT = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADR_WIDTH-1:0]       i_adr,
    input  logic [DAT_WIDTH-1:0]       i_dat_w,
    output logic [DAT_WIDTH-1:0]       i_dat_r,
    input  logic                       i_cyc,
    input  logic                       i_stb,
    input  logic                       i_we,
    input  logic [DAT_WIDTH/8-1:0]     i_sel,
    output logic                       i_ack,
    output logic                       i_err,
    output logic [ADR_WIDTH-1:0]       t_adr,
    output logic [DAT_WIDTH-1:0]       t_dat_w,
    output logic                       t_we,
    output logic [DAT_WIDTH/8-1:0]     t_sel,
    output logic [N_TGT-1:0]           t_cyc,
    output logic [N_TGT-1:0]           t_stb,
    input  logic [N_TGT*DAT_WIDTH-1:0] t_dat_r,
    input  logic [N_TGT-1:0]           t_ack,
    input  logic [N_TGT-1:0]           t_err
);
    localparam int SW = N_TGT > 1 ? $clog2(N_TGT) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    state_t        r_state;
    logic [SW-1:0] r_sel;
    logic          w_hit;
    logic [SW-1:0] w_idx;
    logic          w_act;
    logic          w_rsp;
    logic          w_to;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--)
            if ((i_adr & TGT_ADDR_MASK[i*ADR_WIDTH +: ADR_WIDTH]) == TGT_ADDR_BASE[i*ADR_WIDTH +: ADR_WIDTH]) begin
                w_hit = 1'b1;
                w_idx = SW'(i);
            end
    end

    assign w_act   = r_state == ACTIVE;
    assign w_rsp   = t_ack[r_sel] | t_err[r_sel];
    assign t_adr   = i_adr;
    assign t_dat_w = i_dat_w;
    assign t_we    = i_we;
    assign t_sel   = i_sel;
    assign t_cyc   = (w_act && !w_to) ? (N_TGT'(i_cyc) << r_sel) : '0;
    assign t_stb   = (w_act && !w_to) ? (N_TGT'(i_stb) << r_sel) : '0;
    assign i_ack   = w_act & t_ack[r_sel];
    assign i_err   = (w_act & t_err[r_sel]) | (r_state == ERR);
    assign i_dat_r = t_dat_r[r_sel*DAT_WIDTH +: DAT_WIDTH];

`ifdef WB_DEC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // A response in the timeout cycle wins over the watchdog.
    assign w_to = w_act && !w_rsp && r_cnt == CW'(TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset || !w_act)
            r_cnt <= '0;
        else if (!w_rsp)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_to = TIMEOUT < 0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_cyc && i_stb) begin
                    r_state <= w_hit ? ACTIVE : ERR;
                    if (w_hit)
                        r_sel <= w_idx;
                end
                ACTIVE: if (w_rsp || !i_cyc)
                    r_state <= IDLE;
                else if (w_to)
                    r_state <= ERR;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_interconnect_dec.md
Name: wb_interconnect_dec

Overview:
Wishbone 1-initiator-to-N-target address decoder and router. It is the target-side counterpart of the interconnect arbiter: the arbiter merges initiators onto one channel, and this block fans that channel out to N targets.
- Decodes the address and registers the target selection.
- Passes the transaction through to the selected target and muxes the selected target's response back.
- Terminates accesses to unmapped addresses with a Wishbone error.

Parameters:
ADR_WIDTH, 32, address width.
DAT_WIDTH, 32, data width; sel width is DAT_WIDTH/8.
N_TGT, 2, number of targets (>=1).
TGT_ADDR_BASE, 0, packed N_TGT*ADR_WIDTH vector; slice i is the base address of target i.
TGT_ADDR_MASK, 0, packed N_TGT*ADR_WIDTH vector; slice i is the decode mask of target i.
TIMEOUT, 255, watchdog limit in cycles; used only with WB_DEC_TIMEOUT_EN.

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
i_adr  in  ADR_WIDTH  initiator address
i_dat_w  in  DAT_WIDTH  initiator write data
i_dat_r  out  DAT_WIDTH  read data muxed from the selected target
i_cyc  in  1  initiator cycle
i_stb  in  1  initiator strobe
i_we  in  1  write enable
i_sel  in  DAT_WIDTH/8  byte selects
i_ack  out  1  acknowledge to initiator
i_err  out  1  error to initiator
t_adr  out  ADR_WIDTH  shared target address (= i_adr)
t_dat_w  out  DAT_WIDTH  shared write data (= i_dat_w)
t_we  out  1  shared write enable (= i_we)
t_sel  out  DAT_WIDTH/8  shared byte selects (= i_sel)
t_cyc  out  N_TGT  per-target cycle
t_stb  out  N_TGT  per-target strobe
t_dat_r  in  N_TGT*DAT_WIDTH  packed target read data
t_ack  in  N_TGT  per-target acknowledge
t_err  in  N_TGT  per-target error

Behaviour:
- Decode: hit[i] = ((i_adr & MASK_i) == BASE_i). If several targets hit, the lowest index wins.
- Registered state: state {IDLE, ACTIVE, ERR} and sel_q (index of the selected target).
- Reset values: state=IDLE, sel_q=0; t_cyc=0, t_stb=0, i_ack=0, i_err=0. i_dat_r = slice sel_q of t_dat_r.
- Reset asserted mid-transfer: returns to IDLE at that edge, and t_cyc/t_stb drop in the same cycle.

IDLE:
- All t_cyc/t_stb = 0; i_ack = i_err = 0.
- On i_cyc & i_stb with any hit: sel_q <= winning index, go to ACTIVE.
- On i_cyc & i_stb with no hit: go to ERR.

ACTIVE:
- t_cyc[sel_q] = i_cyc and t_stb[sel_q] = i_stb (combinational); all other bits are 0.
- i_ack = t_ack[sel_q] and i_err = t_err[sel_q] (combinational); acks/errs from unselected targets are ignored.
- On t_ack[sel_q] | t_err[sel_q]: go to IDLE.
- On i_cyc = 0 (abort): go to IDLE; no response is given.

ERR:
- i_err = 1 for exactly one cycle; no t_cyc/t_stb asserted; next state IDLE.

Latency and throughput:
- Target sees stb one cycle after the initiator request (decode is registered).
- Read data and ack are returned with zero added latency after the target responds.
- Unmapped access: i_err is asserted in the cycle after the request.
- One transaction at a time, with a minimum one-cycle IDLE gap between transactions.
- Classic Wishbone: the initiator drops stb after ack/err. If stb is still held in IDLE, it is decoded as a new request.

Optional Feature:
WB_DEC_TIMEOUT_EN:
- Defined: a counter of width $clog2(TIMEOUT+1) clears on entry to ACTIVE and increments each ACTIVE cycle without a selected response.
  - When the counter equals TIMEOUT: drop t_cyc/t_stb and go to ERR, giving a one-cycle i_err.
  - A response arriving in the same cycle as the timeout wins (normal ack/err passthrough, go to IDLE).
- Not defined: no counter; ACTIVE waits indefinitely for a response or an abort.

Test Plan:
- Setup for all scenarios: N_TGT=2, BASE0=0x0000_0000, MASK0=0xFFFF_0000, BASE1=0x1000_0000, MASK1=0xFFFF_0000.
- Write 0xDEADBEEF to 0x1000_0004 -> t_stb=2'b10 one cycle after request; t_dat_w=0xDEADBEEF, t_we=1; target acks -> i_ack in the same cycle; back to IDLE next cycle.
- Read 0x0000_0010, target0 returns 0x12345678 with ack after 3 wait states -> i_dat_r=0x12345678 with i_ack; t_stb[1] never asserted; a spurious t_ack[1] is ignored.
- Access 0x2000_0000 (unmapped) -> i_err=1 for exactly one cycle, one cycle after request; t_cyc stays 0.
- Overlap: set BASE1=0, MASK1=0 (matches everything), access 0x0000_0000 -> target0 selected.
- Abort: drop i_cyc while ACTIVE -> t_cyc/t_stb low the same cycle; IDLE next cycle; no i_ack. Reset asserted during ACTIVE -> all outputs 0 after the edge.
- With WB_DEC_TIMEOUT_EN and TIMEOUT=8, target never acks -> i_err pulses once 8 ACTIVE cycles after entry, then IDLE; ack arriving at cycle 8 -> i_ack, no i_err.
